// File: rtl/mem_bridge.sv
// mem_bridge: single-outstanding-access bridge between a CPU port and an
// external memory with request/acknowledge handshake.
//
// Parameters:
//   TIMEOUT  REQ-state cycles without mem_ack before an access is aborted
//            (1..255, only meaningful with MEM_BRIDGE_TIMEOUT_EN defined)
//
// Optional feature macro: MEM_BRIDGE_TIMEOUT_EN
//   defined   -> REQ is bounded by TIMEOUT cycles; abort returns 0xFF, sets err
//   undefined -> REQ waits for mem_ack forever, err tied low
//
// Ports:
//   clk, nrst                  clock, async active-low reset
//   cpu_addr, cpu_wdata        CPU address / store data
//   cpu_rom_en/rd_en/wr_en     fetch / load / store requests (wr > rd > fetch)
//   cpu_rdata, cpu_data_sel    returned byte; 1 = RAM access, 0 = fetch
//   cpu_valid                  one-cycle completion pulse
//   busy                       state != IDLE
//   mem_req, mem_we            external strobe and write flag
//   mem_addr, mem_wdata        external address / write data
//   mem_ack, mem_rdata         external acknowledge / read data
//   err                        sticky timeout flag
//
// state | meaning
// IDLE  | waiting for a CPU enable; only state that accepts a request
// REQ   | mem_req asserted, address/data/we held, waiting for mem_ack
// RESP  | cpu_valid pulse, response byte presented

module mem_bridge #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rom_en,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_data_sel,
  output logic        cpu_valid,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        err
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {KIND_FETCH = 2'd0, KIND_READ = 2'd1, KIND_WRITE = 2'd2} kind_t;

  state_t state, state_nxt;
  kind_t  kind, kind_in;
  logic   accept;
  logic   ack_take;
  logic   timeout_hit;

  always_comb begin
    kind_in = KIND_FETCH;
    if (cpu_wr_en)      kind_in = KIND_WRITE;
    else if (cpu_rd_en) kind_in = KIND_READ;
  end

  assign accept   = (state == IDLE) && (cpu_wr_en || cpu_rd_en || cpu_rom_en);
  assign ack_take = (state == REQ) && mem_ack;

`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt;
  logic       err_q;

  // Ack has priority over the limit, so the abort only fires when ack is low.
  assign timeout_hit = (state == REQ) && !mem_ack && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt   <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if (accept)              cnt <= 8'd0;
      else if (state == REQ)   cnt <= cnt + 8'd1;
      if (timeout_hit)         err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = REQ;
      REQ:     if (ack_take || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_addr     <= 16'h0000;
      mem_wdata    <= 8'h00;
      mem_we       <= 1'b0;
      kind         <= KIND_FETCH;
      cpu_rdata    <= 8'h00;
      cpu_data_sel <= 1'b0;
    end else begin
      if (accept) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        kind      <= kind_in;
        mem_we    <= (kind_in == KIND_WRITE);
      end
      if (ack_take) begin
        cpu_rdata    <= (kind == KIND_WRITE) ? 8'h00 : mem_rdata;
        cpu_data_sel <= (kind != KIND_FETCH);
      end else if (timeout_hit) begin
        cpu_rdata    <= 8'hFF;
        cpu_data_sel <= (kind != KIND_FETCH);
      end
    end
  end

  assign mem_req   = (state == REQ);
  assign cpu_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

  logic        clk = 1'b0;
  logic        nrst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rom_en, cpu_rd_en, cpu_wr_en;
  logic [7:0]  cpu_rdata;
  logic        cpu_data_sel, cpu_valid, busy;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_bridge #(.TIMEOUT(15)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rom_en(cpu_rom_en), .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
    .cpu_rdata(cpu_rdata), .cpu_data_sel(cpu_data_sel), .cpu_valid(cpu_valid),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    nrst = 1'b0; cpu_addr = 16'hFFFF; cpu_wdata = 8'hFF;
    cpu_rom_en = 1'b0; cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL reset_cpu_valid got %b exp 0", cpu_valid); end
    checks++; if (cpu_data_sel !== 1'b0) begin errors++; $display("FAIL reset_data_sel got %b exp 0", cpu_data_sel); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr); end
    checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata got %h exp 00", mem_wdata); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_cpu_rdata got %h exp 00", cpu_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    cpu_rd_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy got %b exp 0", busy); end
    cpu_rd_en = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch;
    cpu_rom_en = 1'b1; cpu_addr = 16'h0102; cpu_wdata = 8'h77;
    mem_ack = 1'b1; mem_rdata = 8'h3E;
    @(negedge clk);
    cpu_rom_en = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL fetch_mem_req got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 16'h0102) begin errors++; $display("FAIL fetch_mem_addr got %h exp 0102", mem_addr); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we got %b exp 0", mem_we); end
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL fetch_early_valid got %b exp 0", cpu_valid); end
    @(negedge clk);
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b exp 1", cpu_valid); end
    checks++; if (cpu_rdata !== 8'h3E) begin errors++; $display("FAIL fetch_rdata got %h exp 3e", cpu_rdata); end
    checks++; if (cpu_data_sel !== 1'b0) begin errors++; $display("FAIL fetch_data_sel got %b exp 0", cpu_data_sel); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_resp_req got %b exp 0", mem_req); end
    mem_ack = 1'b0; mem_rdata = 8'h99;
    @(negedge clk);
    checks++; if (cpu_valid !== 1'b0) begin errors++; $display("FAIL fetch_valid_pulse got %b exp 0", cpu_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_idle_busy got %b exp 0", busy); end
    checks++; if (cpu_rdata !== 8'h3E) begin errors++; $display("FAIL fetch_rdata_hold got %h exp 3e", cpu_rdata); end
  endtask

  task automatic test_store;
    int nreq;
    nreq = 0;
    cpu_wr_en = 1'b1; cpu_addr = 16'h8000; cpu_wdata = 8'hA5;
    mem_ack = 1'b0; mem_rdata = 8'h5C;
    @(negedge clk);
    cpu_wr_en = 1'b0; cpu_wdata = 8'h00; cpu_addr = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      if (mem_req === 1'b1) nreq++;
      if (i == 4) mem_ack = 1'b1;
    end
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL store_mem_we got %b exp 1", mem_we); end
    checks++; if (mem_wdata !== 8'hA5) begin errors++; $display("FAIL store_mem_wdata got %h exp a5", mem_wdata); end
    checks++; if (mem_addr !== 16'h8000) begin errors++; $display("FAIL store_mem_addr got %h exp 8000", mem_addr); end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (nreq !== 5) begin errors++; $display("FAIL store_req_cycles got %0d exp 5", nreq); end
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL store_valid got %b exp 1", cpu_valid); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL store_rdata got %h exp 00", cpu_rdata); end
    checks++; if (cpu_data_sel !== 1'b1) begin errors++; $display("FAIL store_data_sel got %b exp 1", cpu_data_sel); end
    @(negedge clk);
  endtask

  task automatic test_collision;
    int wr_seen;
    wr_seen = 0;
    cpu_rd_en = 1'b1; cpu_rom_en = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'h66;
    mem_ack = 1'b0; mem_rdata = 8'h5A;
    @(negedge clk);
    cpu_rd_en = 1'b0; cpu_rom_en = 1'b0; cpu_wr_en = 1'b1; cpu_addr = 16'hBEEF;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL coll_mem_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL coll_mem_addr got %h exp 1234", mem_addr); end
    @(negedge clk);
    cpu_wr_en = 1'b0; mem_ack = 1'b1;
    checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL coll_addr_stable got %h exp 1234", mem_addr); end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL coll_valid got %b exp 1", cpu_valid); end
    checks++; if (cpu_data_sel !== 1'b1) begin errors++; $display("FAIL coll_data_sel got %b exp 1", cpu_data_sel); end
    checks++; if (cpu_rdata !== 8'h5A) begin errors++; $display("FAIL coll_rdata got %h exp 5a", cpu_rdata); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1 || busy === 1'b1) wr_seen++;
    end
    checks++; if (wr_seen !== 0) begin errors++; $display("FAIL coll_write_issued got %0d exp 0", wr_seen); end
  endtask

  task automatic run_ok_fetch(input logic [15:0] a, input logic [7:0] d);
    cpu_rom_en = 1'b1; cpu_addr = a; mem_ack = 1'b1; mem_rdata = d;
    @(negedge clk);
    cpu_rom_en = 1'b0;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

`ifdef MEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    int nreq;
    nreq = 0;
    cpu_rd_en = 1'b1; cpu_addr = 16'h0042; mem_ack = 1'b0; mem_rdata = 8'h12;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    for (int i = 0; i < 40 && cpu_valid !== 1'b1; i++) begin
      if (i != 0) @(negedge clk);
      if (mem_req === 1'b1) nreq++;
    end
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL tmo_valid got %b exp 1", cpu_valid); end
    checks++; if (nreq !== 15) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 15", nreq); end
    checks++; if (cpu_rdata !== 8'hFF) begin errors++; $display("FAIL tmo_rdata got %h exp ff", cpu_rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", err); end
    @(negedge clk);
    run_ok_fetch(16'h0010, 8'h11);
    checks++; if (cpu_rdata !== 8'h11) begin errors++; $display("FAIL tmo_next_rdata got %h exp 11", cpu_rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL tmo_err_sticky got %b exp 1", err); end
    @(negedge clk);
  endtask
`else
  task automatic test_no_timeout;
    int nvalid;
    nvalid = 0;
    cpu_rd_en = 1'b1; cpu_addr = 16'h0042; mem_ack = 1'b0; mem_rdata = 8'h12;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_valid === 1'b1) nvalid++;
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL notmo_valid got %0d exp 0", nvalid); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL notmo_req got %b exp 1", mem_req); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL notmo_err got %b exp 0", err); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++; if (cpu_valid !== 1'b1) begin errors++; $display("FAIL notmo_late_valid got %b exp 1", cpu_valid); end
    checks++; if (cpu_rdata !== 8'h12) begin errors++; $display("FAIL notmo_rdata got %h exp 12", cpu_rdata); end
    @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid;
    int nvalid;
    nvalid = 0;
    cpu_rd_en = 1'b1; cpu_addr = 16'h4321; mem_ack = 1'b0; mem_rdata = 8'hC3;
    @(negedge clk);
    cpu_rd_en = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req got %b exp 1", mem_req); end
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rstmid_addr got %h exp 0000", mem_addr); end
    mem_ack = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cpu_valid === 1'b1 || busy === 1'b1) nvalid++;
    end
    mem_ack = 1'b0;
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL rstmid_after_release got %0d exp 0", nvalid); end
    checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL rstmid_rdata got %h exp 00", cpu_rdata); end
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store;
    test_collision;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
